// File: rtl/unreg_word_serializer.sv
// Captures active-low words from the unregistered select/invert stage, buffers them in a FIFO
// and shifts each one out LSB-first with frame markers. Optional parity bit: UNREG_SER_PARITY_EN.
module unreg_word_serializer #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter bit INVERT_IN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           din,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic                       sout,
    output logic                       sout_valid,
    input  logic                       sout_ready,
    output logic                       sout_first,
    output logic                       sout_last,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

    state_t            state, next_state;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  shreg;
    logic [IW-1:0]     idx;
    logic              full, empty, push, pop, last_bit;
`ifdef UNREG_SER_PARITY_EN
    logic              par;
`endif

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    // Ready is forced low during reset so the upstream sees no acceptance window.
    assign din_ready = !rst && !full;
    assign push     = din_valid && din_ready;
    assign pop      = (state == IDLE) && !empty;
    assign last_bit = (idx == IW'(WIDTH - 1));
    assign fifo_count = count;
    assign busy     = !empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= INVERT_IN ? ~din : din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            idx   <= '0;
`ifdef UNREG_SER_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (pop) begin
            shreg <= mem[rd_ptr];
            idx   <= '0;
`ifdef UNREG_SER_PARITY_EN
            par   <= ^mem[rd_ptr];
`endif
        end else if (state == SHIFT && sout_ready) begin
            shreg <= shreg >> 1;
            idx   <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (!empty) next_state = SHIFT;
            SHIFT: if (sout_ready && last_bit)
`ifdef UNREG_SER_PARITY_EN
                       next_state = PAR;
            PAR:   if (sout_ready) next_state = IDLE;
`else
                       next_state = IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sout       = 1'b0;
        sout_valid = 1'b0;
        sout_first = 1'b0;
        sout_last  = 1'b0;
        case (state)
            SHIFT: begin
                sout_valid = 1'b1;
                sout       = shreg[0];
                sout_first = (idx == '0);
`ifndef UNREG_SER_PARITY_EN
                sout_last  = last_bit;
`endif
            end
`ifdef UNREG_SER_PARITY_EN
            PAR: begin
                sout_valid = 1'b1;
                sout       = par;
                sout_last  = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: doc/unreg_word_serializer.md
Name: unreg_word_serializer

Overview:
- Downstream consumer of the 16-bit unregistered select/invert stage.
- Captures its active-low 16-bit result word through a valid/ready handshake.
- Restores true polarity and buffers words in a small FIFO.
- Serializes each word LSB-first onto a 1-bit stream with frame markers and backpressure. It gives the purely combinational upstream datapath a registered, flow-controlled output.

Parameters:
- WIDTH, 16, bits per word; matches the upstream output count.
- DEPTH, 4, FIFO entries; must be a power of two, 2..16.
- INVERT_IN, 1, 1 = input word is active-low and is inverted on capture; 0 = stored as-is.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  WIDTH  upstream word; din[0] is driven by the upstream bit-0 output.
- din_valid  in  1  upstream word is valid this cycle.
- din_ready  out  1  FIFO can accept a word.
- sout  out  1  serial data bit.
- sout_valid  out  1  sout is valid.
- sout_ready  in  1  sink accepts the current bit.
- sout_first  out  1  current bit is bit 0 of a frame.
- sout_last  out  1  current bit is the final bit of a frame.
- fifo_count  out  clog2(DEPTH)+1  words currently buffered.
- busy  out  1  FIFO non-empty or frame in progress.

Behaviour:
- Reset values while rst is high: all outputs 0, including din_ready, sout, sout_valid, sout_first, sout_last, fifo_count and busy. FIFO pointers 0, FSM in IDLE, shift register 0.
- Reset release: din_ready rises combinationally once rst is low and the FIFO is not full.
- Push: occurs on din_valid & din_ready. Stored word = INVERT_IN ? ~din : din. Word is visible in fifo_count the next cycle.
- din_ready = !full; it is purely registered-state derived, with no dependence on din_valid.
- Pop: performed only by the FSM in IDLE when fifo_count != 0.
- Same-cycle push and pop: count unchanged; pointers each advance by 1 and wrap modulo DEPTH.
- Push while full is impossible because din_ready is 0. Pop while empty is impossible.
- FSM states:
  - IDLE: sout_valid = 0. If count != 0, pop head into shift register, bit index = 0, go to SHIFT.
  - SHIFT: sout_valid = 1, sout = shreg[0], sout_first = (idx == 0), sout_last = (idx == WIDTH-1) in non-parity builds.
    - On sout_ready: shift right, idx++.
    - If idx == WIDTH-1 is accepted: go to PAR if PARITY_EN, else IDLE.
    - Without sout_ready: all outputs hold stable.
  - PAR: present only with PARITY_EN; see below.
- Latency: word pushed at edge N → in FIFO after N → popped at edge N+1 → first bit valid in cycle after edge N+1.
- Minimum frame period: WIDTH+1 cycles (one IDLE cycle per frame). There are no back-to-back frames without an IDLE gap.
- busy = (count != 0) | (state != IDLE).
- Reset mid-frame: frame is aborted immediately, FIFO contents discarded, no partial completion after release.
- Upstream changes to din while din_valid is low are ignored.

Optional Feature:
- Macro: UNREG_SER_PARITY_EN.
- Defined:
  - After bit WIDTH-1 is accepted, FSM enters PAR.
  - PAR drives sout = XOR of the stored (polarity-restored) word, sout_valid = 1, sout_last = 1. The bit is held until sout_ready, then the FSM returns to IDLE.
  - sout_last is 0 on data bit WIDTH-1.
  - Parity register is computed at pop time.
  - Frame length is WIDTH+1 bits.
- Undefined:
  - PAR state and parity logic are absent.
  - Frame length is WIDTH bits; sout_last marks bit WIDTH-1.

Test Plan:
- Reset then single word, sout_ready = 1: din = 16'h5A3C (= ~16'hA5C3), one-cycle din_valid → sout sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. sout_first on the first bit, sout_last on the 16th, busy low afterward.
- Fill FIFO, sink stalled (sout_ready = 0): push 5 words back-to-back. First word is popped into the shift register, 4 remain buffered, din_ready = 0 with fifo_count = 4. The 6th push is not accepted. Releasing sout_ready drains all 5 frames in order with one IDLE cycle between frames.
- Backpressure mid-frame: deassert sout_ready at bit 7 for 3 cycles → sout, sout_valid and sout_first/last stay frozen. Bit 8 appears after release, with no bit lost or duplicated.
- Simultaneous push/pop: FIFO count = 2, push coincident with an IDLE pop → count stays 2. Order is preserved across pointer wrap after 8 total words.
- Async reset mid-frame: assert rst at bit 5 of a frame with 3 words buffered → outputs 0 immediately, fifo_count = 0. After release, no stream output until a new push.
- With UNREG_SER_PARITY_EN, INVERT_IN = 1: din = 16'hFFFE → 16 data bits 1,0,…,0 followed by a 17th bit = 1. sout_last only on the 17th bit.
